bram_fifo_ctrl: RTL and testbench
=================================

// Module: bram_fifo_ctrl
// PURPOSE
//  Show-ahead (first-word-fall-through) FIFO controller around one DP_BRAM instance.
//  Owns the write/read pointers and hides the BRAM's 1-cycle registered read behind a 2-entry output buffer.
//  Gives 1 word/cycle valid/ready streaming between GACT tile stages (e.g. traceback pointers, tile sequence chunks).
// PARAMETERS
//  ADDR_WIDTH  4  BRAM address bits; DEPTH = 2**ADDR_WIDTH words.
//  DATA_WIDTH  8  word width, passed straight to DP_BRAM.
//  AF_THRESH   12 almost_full asserts when level >= AF_THRESH (0..DEPTH+2).
// PORTS
//  clk          in   1             single clock; all state on posedge
//  rst_n        in   1             asynchronous, active-low reset
//  flush        in   1             synchronous clear of all contents
//  in_valid     in   1             producer word valid
//  in_ready     out  1             controller can accept (registered)
//  in_data      in   DATA_WIDTH    producer word
//  out_valid    out  1             out_data holds the oldest word
//  out_ready    in   1             consumer pops when out_valid&&out_ready
//  out_data     out  DATA_WIDTH    head word, stable while out_valid&&!out_ready
//  level        out  ADDR_WIDTH+2  words held (BRAM + in-flight + buffer)
//  almost_full  out  1             level >= AF_THRESH (registered)
// BEHAVIOUR
//  Reset (rst_n=0, async): wr_ptr=rd_ptr=0, inflight=0, buffer empty; out_valid=0, out_data=0, level=0,
//   in_ready=0, almost_full=0. in_ready rises on the first posedge after rst_n deasserts. BRAM contents untouched.
//  Pointers are ADDR_WIDTH+1 bits (wrap bit); bram_cnt = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1).
//  push = in_valid&&in_ready -> BRAM wr_en=1, waddr=wr_ptr[ADDR_WIDTH-1:0], wr_ptr+1.
//  in_ready(next) = (bram_cnt_next < DEPTH) && !flush. Push with in_ready=0 is ignored, no state change.
//  fetch (combinational): bram_cnt!=0 && (ob_cnt + inflight - pop) < 2 -> raddr=rd_ptr, rd_ptr+1, inflight<=1.
//   A word pushed on edge N is fetchable from cycle N+1 only; the same-cycle read-first hazard is never exercised.
//  inflight=1: the BRAM data_out is written into the buffer tail on the next edge.
//  Output buffer: 2-entry register FIFO (head/skid). The head drives out_data/out_valid.
//   A pop and a BRAM return on the same edge keep order: the skid moves to the head, the return goes to the skid.
//  Latency: push accepted in cycle t into an empty block -> out_valid=1 in cycle t+3. Sustained 1 word/cycle both ways.
//  Capacity DEPTH+2. level = bram_cnt + inflight + ob_cnt, updated each edge; almost_full compares level_next.
//  Full (bram_cnt==DEPTH): in_ready=0; a pop frees BRAM space, so in_ready=1 on the following cycle.
//  Empty: out_valid=0; out_ready is don't-care; no underflow is possible.
//  Simultaneous push+pop at any level: both take effect, level unchanged.
//  flush: on that edge wr_ptr=rd_ptr=0, inflight=0, buffer cleared, out_valid=0, level=0, in_ready=0 for one cycle.
//   A push in the same cycle is dropped. An in-flight BRAM return is discarded.
//  rst_n asserted mid-stream: immediate return to the reset values; partial transfers are lost.
// STRUCTURE
//  Sub-module: existing DP_BRAM #(ADDR_WIDTH,DATA_WIDTH) as u_mem. No other instances.
//  Shared package darwin_pkg: localparam helper DEPTH=2**ADDR_WIDTH usage, OB_DEPTH=2. No typedefs needed.
//  Internal: pointer/count logic, fetch decision, 2-entry output buffer. Target ~200 RTL lines.
// TESTING (ADDR_WIDTH=4, DATA_WIDTH=8, AF_THRESH=12)
//  1 Reset: hold rst_n=0 3 cycles -> out_valid=0, level=0, in_ready=0; in_ready=1 one cycle after release.
//  2 Latency: push 0xA5 at cycle t, out_ready=1 -> out_valid=1 with out_data=0xA5 at t+3, then 0 at t+4.
//  3 Fill: out_ready=0, push 0x00..0x13 -> 18 accepted (in_ready=0 after the 18th), level=18,
//    almost_full=1 from level 12; pop 18 -> 0x00..0x11 in order.
//  4 Streaming: in_valid=out_ready=1 for 100 cycles with an incrementing pattern -> 1 word/cycle,
//    no gaps after the first, level constant, wr_ptr wraps cleanly.
//  5 Backpressure: random out_ready at 50%, random in_valid -> scoreboard exact order; out_data stable while stalled.
//  6 Flush: level=7 with a read in flight, flush=1 plus push 0xFF -> level=0, out_valid=0 next cycle,
//    0xFF never appears; next push 0x3C emerges first.

Source files
------------

// File: rtl/darwin_pkg.sv
// rtl/darwin_pkg.sv - shared constants and helpers for Darwin GACT tile FIFOs
package darwin_pkg;

  // Output buffer hides the one-cycle BRAM read: head plus one skid entry.
  localparam int unsigned OB_DEPTH = 2;
  localparam int unsigned OB_CNT_W = 2;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/DP_BRAM.sv
// rtl/DP_BRAM.sv - simple dual-port block RAM, one write port and one registered read port
module DP_BRAM #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  // Read-first, no reset: contents and read register survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[waddr] <= data_in;
    end
    data_out <= mem[raddr];
  end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// rtl/bram_fifo_ctrl.sv - show-ahead FIFO controller around one DP_BRAM
// Pointers and fetch logic feed a 2-entry head/skid buffer that masks the registered BRAM read.
module bram_fifo_ctrl
  import darwin_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int AF_THRESH  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  almost_full
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int PW = ADDR_WIDTH + 1;
  localparam int LW = ADDR_WIDTH + 2;
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [LW-1:0] AF_C    = LW'(AF_THRESH);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         bram_cnt, bram_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [OB_CNT_W-1:0]   ob_cnt_q, ob_cnt_d;
  logic [DATA_WIDTH-1:0] ob_head_q, ob_head_d, ob_skid_q, ob_skid_d;
  logic                  in_ready_q, in_ready_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  af_q, af_d;
  logic                  push, pop, fetch;
  logic [2:0]            occ;
  logic [DATA_WIDTH-1:0] bram_rdata;

  assign out_valid   = (ob_cnt_q != '0);
  assign out_data    = ob_head_q;
  assign in_ready    = in_ready_q;
  assign level       = level_q;
  assign almost_full = af_q;

  always_comb begin
    push     = in_valid && in_ready_q && !flush;
    pop      = out_valid && out_ready;
    bram_cnt = wr_ptr_q - rd_ptr_q;
    // Only fetch when the word is guaranteed a buffer slot on return.
    occ      = 3'(ob_cnt_q) + 3'(inflight_q) - 3'(pop);
    fetch    = (bram_cnt != '0) && (occ < 3'(OB_DEPTH));

    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(fetch);
    inflight_d = fetch;
    ob_head_d  = ob_head_q;
    ob_skid_d  = ob_skid_q;
    ob_cnt_d   = ob_cnt_q;

    if (pop) begin
      ob_head_d = ob_skid_q;
      ob_cnt_d  = ob_cnt_q - 1'b1;
    end
    if (inflight_q) begin
      if (ob_cnt_d == '0) begin
        ob_head_d = bram_rdata;
      end else begin
        ob_skid_d = bram_rdata;
      end
      ob_cnt_d = ob_cnt_d + 1'b1;
    end

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      inflight_d = 1'b0;
      ob_cnt_d   = '0;
      ob_head_d  = '0;
    end

    bram_cnt_d = wr_ptr_d - rd_ptr_d;
    level_d    = LW'(bram_cnt_d) + LW'(inflight_d) + LW'(ob_cnt_d);
    in_ready_d = (bram_cnt_d < DEPTH_C) && !flush;
    af_d       = (level_d >= AF_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      ob_cnt_q   <= '0;
      ob_head_q  <= '0;
      ob_skid_q  <= '0;
      in_ready_q <= 1'b0;
      level_q    <= '0;
      af_q       <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
      ob_cnt_q   <= ob_cnt_d;
      ob_head_q  <= ob_head_d;
      ob_skid_q  <= ob_skid_d;
      in_ready_q <= in_ready_d;
      level_q    <= level_d;
      af_q       <= af_d;
    end
  end

  DP_BRAM #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .waddr   (wr_ptr_q[ADDR_WIDTH-1:0]),
    .data_in (in_data),
    .raddr   (rd_ptr_q[ADDR_WIDTH-1:0]),
    .data_out(bram_rdata)
  );

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// tb/tb_bram_fifo_ctrl.sv - self-checking bench for bram_fifo_ctrl
module tb_bram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid, in_ready, out_valid, out_ready, almost_full;
  logic [7:0] in_data, out_data;
  logic [5:0] level;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  int         lvl_model = 0;
  logic       hold_v = 1'b0;
  logic [7:0] hold_d = 8'h00;

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       ov;
    logic [7:0] od;
    logic [5:0] lvl;
  } vec_t;
  vec_t vecs[16];

  always #5 clk = ~clk;

  bram_fifo_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .AF_THRESH(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .level      (level),
    .almost_full(almost_full)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs at the clock edge, before DUT registers update: sees this cycle's handshakes.
  task automatic sample();
    logic [7:0] e;
    if (hold_v) begin
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_data", {24'd0, out_data}, {24'd0, hold_d});
    end
    if (!rst_n || flush) begin
      exp_q.delete();
      lvl_model = 0;
      hold_v = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", {24'd0, out_data}, {24'd0, e});
        end
        lvl_model--;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        lvl_model++;
      end
      hold_v = out_valid && !out_ready;
      hold_d = out_data;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    sample();
    #1;
  endtask

  task automatic drive(input logic iv, input logic [7:0] id, input logic ordy);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    drive(1'b0, 8'h00, 1'b1);
    while (level != 6'd0 && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_level0"}, {26'd0, level}, 32'd0);
    chk({name, "_sb_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    drive(1'b0, 8'h00, 1'b0);

    vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 6'd1};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 6'd1};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 6'd1};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 6'd0};
    vecs[4]  = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 6'd1};
    vecs[5]  = '{1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 6'd2};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 6'd2};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 6'd2};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 6'd1};
    vecs[9]  = '{1'b1, 8'h33, 1'b1, 1'b0, 8'h00, 6'd1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 6'd1};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 6'd1};
    vecs[12] = '{1'b1, 8'h44, 1'b1, 1'b0, 8'h00, 6'd1};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 6'd1};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h44, 6'd1};
    vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 6'd0};

    // Reset: held three cycles, in_ready rises one edge after release
    for (int i = 0; i < 3; i++) tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_level", {26'd0, level}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_af", {31'd0, almost_full}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_before", {31'd0, in_ready}, 32'd0);
    tick();
    chk("rel_in_ready_after", {31'd0, in_ready}, 32'd1);

    // Latency and small push/pop patterns, one vector per cycle
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].iv, vecs[i].id, vecs[i].ordy);
      tick();
      chk($sformatf("vec%0d_ov", i), {31'd0, out_valid}, {31'd0, vecs[i].ov});
      if (vecs[i].ov) chk($sformatf("vec%0d_data", i), {24'd0, out_data}, {24'd0, vecs[i].od});
      chk($sformatf("vec%0d_level", i), {26'd0, level}, {26'd0, vecs[i].lvl});
      chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      chk($sformatf("vec%0d_af", i), {31'd0, almost_full}, 32'd0);
    end

    // Fill to capacity with the consumer stalled
    for (int i = 0; i < 20; i++) begin
      int el;
      drive(1'b1, 8'(i), 1'b0);
      tick();
      el = (i < 18) ? i + 1 : 18;
      chk($sformatf("fill%0d_level", i), {26'd0, level}, el);
      chk($sformatf("fill%0d_in_ready", i), {31'd0, in_ready}, {31'd0, (i + 1) < 18});
      chk($sformatf("fill%0d_af", i), {31'd0, almost_full}, {31'd0, el >= 12});
    end
    for (int k = 0; k < 18; k++) begin
      drive(1'b0, 8'h00, 1'b1);
      chk($sformatf("drain%0d_ov", k), {31'd0, out_valid}, 32'd1);
      tick();
      chk($sformatf("drain%0d_level", k), {26'd0, level}, 17 - k);
      if (k == 0) chk("drain_in_ready_back", {31'd0, in_ready}, 32'd1);
    end
    chk("fill_sb_empty", exp_q.size(), 32'd0);

    // Streaming: one word per cycle both ways, pointers wrap several times
    for (int c = 0; c < 100; c++) begin
      drive(1'b1, 8'(c + 8'h40), 1'b1);
      tick();
      chk($sformatf("stream%0d_ov", c), {31'd0, out_valid}, {31'd0, c >= 2});
      chk($sformatf("stream%0d_level", c), {26'd0, level}, (c >= 2) ? 3 : c + 1);
    end
    drain("stream", 10);

    // Random backpressure against the scoreboard and a level model
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      tick();
      chk("bp_level", {26'd0, level}, lvl_model);
      chk("bp_af", {31'd0, almost_full}, {31'd0, lvl_model >= 12});
    end
    drain("bp", 40);

    // Flush with a BRAM read in flight; the same-cycle push must vanish
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'(8'h50 + i), 1'b0);
      tick();
    end
    drive(1'b0, 8'h00, 1'b0);
    tick();
    tick();
    drive(1'b0, 8'h00, 1'b1);
    tick();
    chk("pre_flush_level", {26'd0, level}, 32'd7);
    chk("pre_flush_ov", {31'd0, out_valid}, 32'd1);
    drive(1'b1, 8'hFF, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_level", {26'd0, level}, 32'd0);
    chk("flush_ov", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b0, 8'h00, 1'b0);
    tick();
    chk("post_flush_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_flush_ov", {31'd0, out_valid}, 32'd0);
    chk("post_flush_level", {26'd0, level}, 32'd0);
    drive(1'b1, 8'h3C, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    begin
      int n = 0;
      while (!out_valid && n < 8) begin
        tick();
        n++;
      end
    end
    chk("post_flush_first_valid", {31'd0, out_valid}, 32'd1);
    chk("post_flush_first_data", {24'd0, out_data}, 32'h3C);
    drain("flush", 10);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'h70 + i), 1'b0);
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("async_rst_level", {26'd0, level}, 32'd0);
    chk("async_rst_ov", {31'd0, out_valid}, 32'd0);
    chk("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b0, 8'h00, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rerst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rerst_level", {26'd0, level}, 32'd0);
    chk("rerst_ov", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
